// File: rtl/vram_bank_ctrl_if.sv
// rtl/vram_bank_ctrl_if.sv - CPU, fill and video signal bundle for the banked VRAM controller
interface vram_bank_ctrl_if #(
  parameter int PLANES = 6,
  parameter int AW     = 13,
  parameter int DW     = 8
);
  logic [AW-1:0]        cpu_addr;
  logic [DW-1:0]        cpu_din;
  logic                 cpu_rd;
  logic                 cpu_wr;
  logic [DW-1:0]        cpu_dout;
  logic                 cpu_ack;
  logic [7:0]           rd_bank;
  logic [PLANES-1:0]    wr_mask;
  logic                 fill_start;
  logic [DW-1:0]        fill_val;
  logic [PLANES-1:0]    fill_mask;
  logic                 fill_busy;
  logic                 fill_done;
  logic [AW-1:0]        vid_addr;
  logic [PLANES*DW-1:0] vid_data;

  modport master (
    output cpu_addr, cpu_din, cpu_rd, cpu_wr, rd_bank, wr_mask,
    output fill_start, fill_val, fill_mask, vid_addr,
    input  cpu_dout, cpu_ack, fill_busy, fill_done, vid_data
  );

  modport slave (
    input  cpu_addr, cpu_din, cpu_rd, cpu_wr, rd_bank, wr_mask,
    input  fill_start, fill_val, fill_mask, vid_addr,
    output cpu_dout, cpu_ack, fill_busy, fill_done, vid_data
  );
endinterface

// File: rtl/vram_bank_ctrl.sv
// rtl/vram_bank_ctrl.sv - banked bit-plane VRAM with CPU port, fill engine and video read port
module vram_bank_ctrl #(
  parameter int PLANES = 6,
  parameter int AW     = 13,
  parameter int DW     = 8
) (
  input logic              clk,
  input logic              reset,
  vram_bank_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACK, FILL} state_t;

  state_t            state;
  logic [AW-1:0]     fill_cnt;
  logic [DW-1:0]     fill_val_q;
  logic [PLANES-1:0] fill_mask_q;
  logic              ack_rd_q;
  logic              rd_bad_q;
  logic [7:0]        rd_sel_q;
  logic [DW-1:0]     dout_hold;
  logic              ack_q;
  logic              busy_q;
  logic              done_q;

  logic [AW-1:0]     addr_a;
  logic [DW-1:0]     din_a;
  logic [PLANES-1:0] we_a;
  logic [DW-1:0]     rd_val;
  logic              cpu_go_wr;

  wire [DW-1:0]        rd_a [PLANES];
  wire [PLANES*DW-1:0] vid_flat;

  // Fill owns port A while active; a CPU write only lands when no fill is starting.
  assign cpu_go_wr = (state == IDLE) && !bus.fill_start && bus.cpu_wr;

  always_comb begin
    addr_a = bus.cpu_addr;
    din_a  = bus.cpu_din;
    we_a   = '0;
    if (state == FILL) begin
      addr_a = fill_cnt;
      din_a  = fill_val_q;
      we_a   = fill_mask_q;
    end else if (cpu_go_wr) begin
      we_a = bus.wr_mask;
    end
  end

  for (genvar p = 0; p < PLANES; p++) begin : g_plane
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_q;
    logic [DW-1:0] vid_q;

    always_ff @(posedge clk) begin
      if (we_a[p]) mem[addr_a] <= din_a;
      rd_q <= mem[addr_a];
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) vid_q <= '0;
      else       vid_q <= mem[bus.vid_addr];
    end

    assign rd_a[p]                = rd_q;
    assign vid_flat[p*DW +: DW]   = vid_q;
  end

  // Out-of-range plane selects read back as all ones.
  always_comb begin
    rd_val = '1;
    for (int i = 0; i < PLANES; i++) begin
      if (!rd_bad_q && rd_sel_q == 8'(i)) rd_val = rd_a[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      fill_cnt    <= '0;
      fill_val_q  <= '0;
      fill_mask_q <= '0;
      ack_rd_q    <= 1'b0;
      rd_bad_q    <= 1'b0;
      rd_sel_q    <= '0;
      dout_hold   <= '0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.fill_start) begin
            fill_val_q  <= bus.fill_val;
            fill_mask_q <= bus.fill_mask;
            fill_cnt    <= '0;
            busy_q      <= 1'b1;
            state       <= FILL;
          end else if (bus.cpu_wr) begin
            ack_q    <= 1'b1;
            ack_rd_q <= 1'b0;
            state    <= ACK;
          end else if (bus.cpu_rd) begin
            ack_q    <= 1'b1;
            ack_rd_q <= 1'b1;
            rd_bad_q <= (bus.rd_bank == 8'd0) || (bus.rd_bank > 8'(PLANES));
            rd_sel_q <= bus.rd_bank - 8'd1;
            state    <= ACK;
          end
        end
        ACK: begin
          if (ack_rd_q) dout_hold <= rd_val;
          state <= IDLE;
        end
        FILL: begin
          fill_cnt <= fill_cnt + 1'b1;
          if (&fill_cnt) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cpu_ack   = ack_q;
  assign bus.cpu_dout  = (state == ACK && ack_rd_q) ? rd_val : dout_hold;
  assign bus.fill_busy = busy_q;
  assign bus.fill_done = done_q;
  assign bus.vid_data  = vid_flat;

endmodule
